app_wr_addr_ctrl_mb: RTL and testbench
======================================

Name: app_wr_addr_ctrl_mb

Overview:
- Parametrised write-side DMA address generator for the DDR3 native app interface.
- Registers incoming pixel beats into the write-data FIFO and issues one write command per completed burst.
- Frames rotate through NUM_BUF frame buffers, switching on frame start.
- Adds over the single-buffer generation: partial-burst flush at frame boundaries, command-FIFO backpressure, frame-done reporting for the read side, and a sticky overflow flag.

Parameters:
- BASE_ADDR, 0, DDR address of buffer 0.
- DATA_WD, 256, beat width in bits (multiple of 32).
- ADDR_WD, 28, command address width.
- BURST_LEN, 64, beats per full burst (2..255).
- IW, 1024, frame width in pixels.
- IH, 768, frame height in lines.
- PIX_BYTES, 2, bytes per pixel.
- NUM_BUF, 3, frame buffers (1..4).

Ports:
- I_clk  in  1  clock (write FIFO read-clock and command FIFO write-clock domain).
- I_Rst_n  in  1  reset.
- I_frame_start  in  1  single-cycle pulse marking the first beat time of a new frame.
- I_wren  in  1  beat valid.
- I_wdata  in  DATA_WD  beat data.
- I_cmd_full  in  1  command FIFO full.
- wr_fifo_wren  out  1  write-data FIFO write enable.
- wr_fifo_wdata  out  DATA_WD  write-data FIFO data.
- wr_cmd_wren  out  1  command push.
- wr_cmd_wrcmd  out  3  constant 3'b000 (write).
- wr_cmd_wrbl  out  8  burst length of the pushed command.
- wr_cmd_wraddr  out  ADDR_WD  command start address.
- O_done_pulse  out  1  one-cycle pulse when a frame's last command has been pushed.
- O_done_buf  out  2  index of the buffer just completed.
- O_overflow  out  1  sticky error flag.

Behaviour:
- Reset is I_Rst_n, synchronous, active-low; clock is I_clk.
- All outputs reset to 0. State resets to S_IDLE, buffer index to 0, offset to 0, beat count to 0.
- Derived constants, with address unit = 32 bits:
  - STEP = BURST_LEN*DATA_WD/32.
  - FRAME_SIZE = IW*IH*PIX_BYTES/4, rounded up to a multiple of STEP.
  - buffer base = BASE_ADDR + idx*FRAME_SIZE, computed at ADDR_WD bits.
- Data path:
  - wr_fifo_wren and wr_fifo_wdata are I_wren and I_wdata registered one cycle, only while not in S_IDLE.
  - Beats in S_IDLE are dropped.
- Beat counter counts accepted beats.
  - On the BURST_LEN-th beat, the counter returns to 0 and a pending command is set with wrbl = BURST_LEN and addr = base + offset.
  - This happens one cycle after the final beat reaches the FIFO, so data always precedes its command.
- Command push:
  - wr_cmd_wren pulses for one cycle when pending = 1 and I_cmd_full = 0, then pending clears.
  - Offset advances by the command's wrbl*DATA_WD/32.
  - If offset reaches FRAME_SIZE, it wraps to 0 within the same buffer.
  - While I_cmd_full = 1, pending holds and wrbl/addr stay stable.
- Overflow:
  - A new burst completing while pending is still set sets O_overflow, and the new command is dropped.
  - O_overflow clears only on reset.
- States:
  - S_IDLE: I_frame_start moves to S_RUN using buffer 0. No switch and no done pulse.
  - S_RUN: normal operation. On I_frame_start:
    - If beat count > 0: pending is set with wrbl = count, addr = base + offset, and the state goes to S_FLUSH.
    - Otherwise the state goes to S_FLUSH directly.
  - S_FLUSH: waits until pending = 0, then goes to S_SWITCH.
  - S_SWITCH, one cycle:
    - O_done_pulse = 1 and O_done_buf = old index.
    - Index becomes (idx+1) mod NUM_BUF.
    - Offset = 0, beat count = 0.
    - Returns to S_RUN.
- Frame-boundary beats:
  - A beat coincident with I_frame_start belongs to the new frame. It is held in a single-beat stage and written once the state returns to S_RUN.
  - Any further I_wren during S_FLUSH/S_SWITCH sets O_overflow and the beat is dropped.
- An I_frame_start during S_FLUSH or S_SWITCH sets O_overflow and is otherwise ignored.
- A frame with zero beats still produces the done pulse.

Test Plan:
Common configuration: DATA_WD=256, BURST_LEN=4, IW=64, IH=2, PIX_BYTES=2, NUM_BUF=3, BASE_ADDR=0, giving STEP=32, FRAME_SIZE=64, bases 0/64/128.
- Start pulse, then 8 continuous beats:
  - 8 FIFO writes, each 1 cycle after input.
  - Commands (bl=4, addr 0) and (bl=4, addr 32), each 1 cycle after its 4th FIFO write.
- 12 beats in one frame: third command at addr 0, wrapped; no overflow.
- Start, 6 beats, start:
  - Commands (4, addr 0) then flush (2, addr 32).
  - O_done_pulse with O_done_buf=0.
  - Next frame's first command at addr 64.
- Four frames of 4 beats each: commands at 0, 64, 128, 0; done_buf sequence 0, 1, 2, 0.
- Hold I_cmd_full high over 2 burst completions:
  - The first command stays pending with addr stable.
  - The second burst sets O_overflow.
  - Release I_cmd_full: exactly one command pushed.
- Reset asserted mid-burst after 2 beats, then start plus 4 beats: all outputs return to 0; the single command has addr 0, bl 4; O_overflow stays 0.

Source files
------------

// File: rtl/app_wr_addr_ctrl_mb.sv
// Write-side DMA address generator for the DDR3 native app interface. It forwards
// pixel beats to the write-data FIFO and pushes one command per burst across NUM_BUF buffers.
module app_wr_addr_ctrl_mb #(
  parameter int BASE_ADDR = 0,
  parameter int DATA_WD   = 256,
  parameter int ADDR_WD   = 28,
  parameter int BURST_LEN = 64,
  parameter int IW        = 1024,
  parameter int IH        = 768,
  parameter int PIX_BYTES = 2,
  parameter int NUM_BUF   = 3
) (
  input  logic               I_clk,
  input  logic               I_Rst_n,
  input  logic               I_frame_start,
  input  logic               I_wren,
  input  logic [DATA_WD-1:0] I_wdata,
  input  logic               I_cmd_full,
  output logic               wr_fifo_wren,
  output logic [DATA_WD-1:0] wr_fifo_wdata,
  output logic               wr_cmd_wren,
  output logic [2:0]         wr_cmd_wrcmd,
  output logic [7:0]         wr_cmd_wrbl,
  output logic [ADDR_WD-1:0] wr_cmd_wraddr,
  output logic               O_done_pulse,
  output logic [1:0]         O_done_buf,
  output logic               O_overflow
);

  localparam int WORDS_PER_BEAT = DATA_WD / 32;
  localparam int STEP           = BURST_LEN * WORDS_PER_BEAT;
  localparam int FRAME_RAW      = IW * IH * PIX_BYTES / 4;
  localparam int FRAME_SIZE     = ((FRAME_RAW + STEP - 1) / STEP) * STEP;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_SWITCH = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [7:0]           cnt_r;
  logic [1:0]           idx_r;
  logic [ADDR_WD-1:0]   offset_r;
  logic                 pend_r;
  logic                 stage_vld_r;
  logic [DATA_WD-1:0]   stage_data_r;

  logic                 fifo_wren_r;
  logic [DATA_WD-1:0]   fifo_wdata_r;
  logic                 cmd_wren_r;
  logic [7:0]           cmd_bl_r;
  logic [ADDR_WD-1:0]   cmd_addr_r;
  logic                 done_pulse_r;
  logic [1:0]           done_buf_r;
  logic                 overflow_r;

  logic                 accept_s;
  logic                 stage_load_s;
  logic                 start_run_s;
  logic                 switch_s;
  logic                 proto_err_s;
  logic                 burst_done_s;
  logic                 flush_s;
  logic                 push_s;
  logic                 new_cmd_s;
  logic                 pend_busy_s;
  logic [7:0]           new_bl_s;
  logic [1:0]           idx_nx_s;
  logic [ADDR_WD-1:0]   base_s;
  logic [ADDR_WD-1:0]   offset_adv_s;
  logic [ADDR_WD-1:0]   offset_nx_s;

  // State register
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (I_frame_start) state_nx_s = S_RUN;
        else               state_nx_s = S_IDLE;
      end
      S_RUN: begin
        if (I_frame_start) state_nx_s = S_FLUSH;
        else               state_nx_s = S_RUN;
      end
      S_FLUSH: begin
        if (!pend_r) state_nx_s = S_SWITCH;
        else         state_nx_s = S_FLUSH;
      end
      S_SWITCH: state_nx_s = S_RUN;
      default:  state_nx_s = S_IDLE;
    endcase
  end

  // Per-state control decode
  always_comb begin
    accept_s     = 1'b0;
    stage_load_s = 1'b0;
    start_run_s  = 1'b0;
    switch_s     = 1'b0;
    proto_err_s  = 1'b0;
    case (state_r)
      S_RUN: begin
        accept_s     = I_wren & ~I_frame_start;
        stage_load_s = I_wren & I_frame_start;
        start_run_s  = I_frame_start;
      end
      S_FLUSH: begin
        proto_err_s = I_wren | I_frame_start;
      end
      S_SWITCH: begin
        switch_s    = 1'b1;
        proto_err_s = I_wren | I_frame_start;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  assign burst_done_s = accept_s & (cnt_r == 8'(BURST_LEN - 1));
  assign flush_s      = start_run_s & (cnt_r != 8'd0);
  assign push_s       = pend_r & ~I_cmd_full;
  assign new_cmd_s    = burst_done_s | flush_s;
  // A command leaving this very cycle frees the slot for the next one.
  assign pend_busy_s  = pend_r & ~push_s;
  assign new_bl_s     = burst_done_s ? 8'(BURST_LEN) : cnt_r;
  assign idx_nx_s     = (idx_r == 2'(NUM_BUF - 1)) ? 2'd0 : idx_r + 2'd1;
  assign base_s       = ADDR_WD'(BASE_ADDR) + ADDR_WD'(idx_r) * ADDR_WD'(FRAME_SIZE);
  assign offset_adv_s = offset_r + ADDR_WD'(cmd_bl_r) * ADDR_WD'(WORDS_PER_BEAT);

  // Offset after any push this cycle, wrapping inside the current buffer
  always_comb begin
    offset_nx_s = offset_r;
    if (push_s) begin
      if (offset_adv_s >= ADDR_WD'(FRAME_SIZE)) offset_nx_s = '0;
      else                                      offset_nx_s = offset_adv_s;
    end else begin
      offset_nx_s = offset_r;
    end
  end

  // Datapath, beat counting, command slot and status registers
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n) begin
      cnt_r        <= 8'd0;
      idx_r        <= 2'd0;
      offset_r     <= '0;
      pend_r       <= 1'b0;
      stage_vld_r  <= 1'b0;
      stage_data_r <= '0;
      fifo_wren_r  <= 1'b0;
      fifo_wdata_r <= '0;
      cmd_wren_r   <= 1'b0;
      cmd_bl_r     <= 8'd0;
      cmd_addr_r   <= '0;
      done_pulse_r <= 1'b0;
      done_buf_r   <= 2'd0;
      overflow_r   <= 1'b0;
    end else begin
      if (switch_s && stage_vld_r) begin
        fifo_wren_r  <= 1'b1;
        fifo_wdata_r <= stage_data_r;
      end else if (accept_s) begin
        fifo_wren_r  <= 1'b1;
        fifo_wdata_r <= I_wdata;
      end else begin
        fifo_wren_r  <= 1'b0;
      end

      if (stage_load_s) begin
        stage_vld_r  <= 1'b1;
        stage_data_r <= I_wdata;
      end else if (switch_s) begin
        stage_vld_r  <= 1'b0;
      end

      // The staged boundary beat opens the new frame's first burst.
      if (switch_s)                      cnt_r <= stage_vld_r ? 8'd1 : 8'd0;
      else if (start_run_s || burst_done_s) cnt_r <= 8'd0;
      else if (accept_s)                 cnt_r <= cnt_r + 8'd1;

      cmd_wren_r <= push_s;
      if (new_cmd_s && !pend_busy_s) begin
        pend_r     <= 1'b1;
        cmd_bl_r   <= new_bl_s;
        cmd_addr_r <= base_s + offset_nx_s;
      end else if (push_s) begin
        pend_r     <= 1'b0;
      end

      if (switch_s) begin
        offset_r <= '0;
        idx_r    <= idx_nx_s;
      end else begin
        offset_r <= offset_nx_s;
      end

      done_pulse_r <= switch_s;
      if (switch_s) done_buf_r <= idx_r;

      if (proto_err_s || (new_cmd_s && pend_busy_s)) overflow_r <= 1'b1;
    end
  end

  assign wr_fifo_wren  = fifo_wren_r;
  assign wr_fifo_wdata = fifo_wdata_r;
  assign wr_cmd_wren   = cmd_wren_r;
  assign wr_cmd_wrcmd  = 3'b000;
  assign wr_cmd_wrbl   = cmd_bl_r;
  assign wr_cmd_wraddr = cmd_addr_r;
  assign O_done_pulse  = done_pulse_r;
  assign O_done_buf    = done_buf_r;
  assign O_overflow    = overflow_r;

endmodule

// File: tb/tb_app_wr_addr_ctrl_mb.sv
// Self-checking bench for app_wr_addr_ctrl_mb: directed scenarios with constant
// expectations plus randomized multi-frame traffic against a frame-level model.
module tb_app_wr_addr_ctrl_mb;

  localparam int DATA_WD = 256;
  localparam int ADDR_WD = 28;
  localparam int BL      = 4;
  localparam int STEP    = 32;
  localparam int FRAME   = 64;
  localparam int NBUF    = 3;

  logic               I_clk = 1'b0;
  logic               I_Rst_n = 1'b0;
  logic               I_frame_start = 1'b0;
  logic               I_wren = 1'b0;
  logic [DATA_WD-1:0] I_wdata = '0;
  logic               I_cmd_full = 1'b0;
  logic               wr_fifo_wren;
  logic [DATA_WD-1:0] wr_fifo_wdata;
  logic               wr_cmd_wren;
  logic [2:0]         wr_cmd_wrcmd;
  logic [7:0]         wr_cmd_wrbl;
  logic [ADDR_WD-1:0] wr_cmd_wraddr;
  logic               O_done_pulse;
  logic [1:0]         O_done_buf;
  logic               O_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  app_wr_addr_ctrl_mb #(
    .BASE_ADDR(0), .DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD), .BURST_LEN(BL),
    .IW(64), .IH(2), .PIX_BYTES(2), .NUM_BUF(NBUF)
  ) dut (
    .I_clk(I_clk), .I_Rst_n(I_Rst_n), .I_frame_start(I_frame_start),
    .I_wren(I_wren), .I_wdata(I_wdata), .I_cmd_full(I_cmd_full),
    .wr_fifo_wren(wr_fifo_wren), .wr_fifo_wdata(wr_fifo_wdata),
    .wr_cmd_wren(wr_cmd_wren), .wr_cmd_wrcmd(wr_cmd_wrcmd),
    .wr_cmd_wrbl(wr_cmd_wrbl), .wr_cmd_wraddr(wr_cmd_wraddr),
    .O_done_pulse(O_done_pulse), .O_done_buf(O_done_buf), .O_overflow(O_overflow)
  );

  always #5 I_clk = ~I_clk;

  always @(posedge I_clk) cyc <= cyc + 1;

  // Observed output events
  logic [DATA_WD-1:0] mf_data[$];
  int                 mf_cyc[$];
  logic [7:0]         mc_bl[$];
  logic [ADDR_WD-1:0] mc_addr[$];
  logic [2:0]         mc_cmd[$];
  int                 mc_cyc[$];
  logic [1:0]         md_buf[$];

  always @(negedge I_clk) begin
    if (I_Rst_n) begin
      if (wr_fifo_wren) begin
        mf_data.push_back(wr_fifo_wdata);
        mf_cyc.push_back(cyc);
      end
      if (wr_cmd_wren) begin
        mc_bl.push_back(wr_cmd_wrbl);
        mc_addr.push_back(wr_cmd_wraddr);
        mc_cmd.push_back(wr_cmd_wrcmd);
        mc_cyc.push_back(cyc);
      end
      if (O_done_pulse) md_buf.push_back(O_done_buf);
    end
  end

  // Frame-level reference model
  int                 m_active, m_buf, m_n;
  logic [DATA_WD-1:0] e_fdata[$];
  int                 e_bl[$];
  int                 e_addr[$];
  int                 e_done[$];

  function automatic int addr_of(int b, int k);
    return b * FRAME + (k * STEP) % FRAME;
  endfunction

  task automatic model_reset();
    m_active = 0; m_buf = 0; m_n = 0;
    e_fdata.delete(); e_bl.delete(); e_addr.delete(); e_done.delete();
  endtask

  task automatic model_start();
    if (m_active == 0) begin
      m_active = 1; m_buf = 0; m_n = 0;
    end else begin
      if (m_n % BL != 0) begin
        e_bl.push_back(m_n % BL);
        e_addr.push_back(addr_of(m_buf, m_n / BL));
      end
      e_done.push_back(m_buf);
      m_buf = (m_buf + 1) % NBUF;
      m_n = 0;
    end
  endtask

  task automatic model_beat(input logic [DATA_WD-1:0] d);
    if (m_active != 0) begin
      e_fdata.push_back(d);
      m_n++;
      if (m_n % BL == 0) begin
        e_bl.push_back(BL);
        e_addr.push_back(addr_of(m_buf, m_n / BL - 1));
      end
    end
  endtask

  function automatic logic [DATA_WD-1:0] rnd_data();
    logic [DATA_WD-1:0] d;
    for (int i = 0; i < DATA_WD / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input logic s, input logic w, input logic [DATA_WD-1:0] d);
    I_frame_start = s; I_wren = w; I_wdata = d;
    @(posedge I_clk); #1;
    I_frame_start = 1'b0; I_wren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic send_beat();
    logic [DATA_WD-1:0] d;
    d = rnd_data();
    model_beat(d);
    drive(1'b0, 1'b1, d);
  endtask

  task automatic send_start(input logic coinc);
    logic [DATA_WD-1:0] d;
    model_start();
    if (coinc) begin
      d = rnd_data();
      model_beat(d);
      drive(1'b1, 1'b1, d);
    end else begin
      drive(1'b1, 1'b0, '0);
    end
  endtask

  task automatic clear_mon();
    mf_data.delete(); mf_cyc.delete(); mc_bl.delete(); mc_addr.delete();
    mc_cmd.delete(); mc_cyc.delete(); md_buf.delete();
  endtask

  task automatic do_reset();
    I_Rst_n = 1'b0; I_cmd_full = 1'b0;
    idle(3);
    I_Rst_n = 1'b1;
    clear_mon();
    model_reset();
  endtask

  task automatic test_reset();
    I_Rst_n = 1'b0;
    drive(1'b1, 1'b1, rnd_data());
    idle(2);
    n_checks++;
    if ({wr_fifo_wren, wr_cmd_wren, O_done_pulse, O_overflow} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 0000", {wr_fifo_wren, wr_cmd_wren, O_done_pulse, O_overflow});
    end
    n_checks++;
    if (wr_fifo_wdata !== '0) begin
      n_errors++; $display("FAIL reset_wdata: got %0h expected 0", wr_fifo_wdata);
    end
    n_checks++;
    if ({wr_cmd_wrcmd, wr_cmd_wrbl, wr_cmd_wraddr, O_done_buf} !== '0) begin
      n_errors++; $display("FAIL reset_cmd: got cmd %0h bl %0d addr %0h buf %0d expected all 0", wr_cmd_wrcmd, wr_cmd_wrbl, wr_cmd_wraddr, O_done_buf);
    end
    do_reset();
  endtask

  task automatic test_burst_timing();
    int in_cyc[$];
    do_reset();
    send_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      in_cyc.push_back(cyc);
      send_beat();
    end
    idle(4);
    n_checks++;
    if (mf_data.size() != 8) begin
      n_errors++; $display("FAIL timing_fifo_count: got %0d expected 8", mf_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (mf_data[i] !== e_fdata[i] || mf_cyc[i] != in_cyc[i] + 1) begin
          n_errors++; $display("FAIL timing_fifo[%0d]: got cyc %0d data %0h expected cyc %0d data %0h", i, mf_cyc[i], mf_data[i], in_cyc[i] + 1, e_fdata[i]);
        end
      end
      n_checks++;
      if (mc_bl.size() != 2) begin
        n_errors++; $display("FAIL timing_cmd_count: got %0d expected 2", mc_bl.size());
      end else begin
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (mc_bl[i] !== 8'd4 || mc_addr[i] !== ADDR_WD'(i * 32) || mc_cyc[i] != mf_cyc[i*4+3] + 1) begin
            n_errors++; $display("FAIL timing_cmd[%0d]: got bl %0d addr %0d cyc %0d expected bl 4 addr %0d cyc %0d", i, mc_bl[i], mc_addr[i], mc_cyc[i], i * 32, mf_cyc[i*4+3] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_start(1'b0);
    for (int i = 0; i < 12; i++) send_beat();
    idle(4);
    n_checks++;
    if (mc_addr.size() != 3) begin
      n_errors++; $display("FAIL wrap_count: got %0d expected 3", mc_addr.size());
    end else begin
      n_checks++;
      if (mc_addr[0] !== 28'd0 || mc_addr[1] !== 28'd32 || mc_addr[2] !== 28'd0) begin
        n_errors++; $display("FAIL wrap_addr: got %0d %0d %0d expected 0 32 0", mc_addr[0], mc_addr[1], mc_addr[2]);
      end
    end
    n_checks++;
    if (O_overflow !== 1'b0) begin
      n_errors++; $display("FAIL wrap_overflow: got %b expected 0", O_overflow);
    end
  endtask

  task automatic test_flush();
    do_reset();
    send_start(1'b0);
    for (int i = 0; i < 6; i++) send_beat();
    send_start(1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) send_beat();
    idle(4);
    n_checks++;
    if (mc_bl.size() != 3) begin
      n_errors++; $display("FAIL flush_count: got %0d expected 3", mc_bl.size());
    end else begin
      n_checks++;
      if (mc_bl[0] !== 8'd4 || mc_addr[0] !== 28'd0 || mc_bl[1] !== 8'd2 || mc_addr[1] !== 28'd32 ||
          mc_bl[2] !== 8'd4 || mc_addr[2] !== 28'd64) begin
        n_errors++; $display("FAIL flush_cmds: got (%0d,%0d) (%0d,%0d) (%0d,%0d) expected (4,0) (2,32) (4,64)",
                             mc_bl[0], mc_addr[0], mc_bl[1], mc_addr[1], mc_bl[2], mc_addr[2]);
      end
    end
    n_checks++;
    if (md_buf.size() != 1 || md_buf[0] !== 2'd0) begin
      n_errors++; $display("FAIL flush_done: got %0d pulses first buf %0d expected 1 pulse buf 0", md_buf.size(), (md_buf.size() > 0) ? md_buf[0] : 2'd3);
    end
    n_checks++;
    if (O_overflow !== 1'b0) begin
      n_errors++; $display("FAIL flush_overflow: got %b expected 0", O_overflow);
    end
  endtask

  task automatic test_rotation();
    logic [ADDR_WD-1:0] exp_addr[4];
    logic [1:0]         exp_buf[4];
    exp_addr = '{28'd0, 28'd64, 28'd128, 28'd0};
    exp_buf  = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    send_start(1'b0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) send_beat();
      send_start(1'b0);
      idle(4);
    end
    n_checks++;
    if (mc_addr.size() != 4 || md_buf.size() != 4) begin
      n_errors++; $display("FAIL rot_count: got %0d cmds %0d dones expected 4 4", mc_addr.size(), md_buf.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (mc_addr[i] !== exp_addr[i] || mc_bl[i] !== 8'd4 || md_buf[i] !== exp_buf[i]) begin
          n_errors++; $display("FAIL rot[%0d]: got addr %0d bl %0d buf %0d expected addr %0d bl 4 buf %0d",
                               i, mc_addr[i], mc_bl[i], md_buf[i], exp_addr[i], exp_buf[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    I_cmd_full = 1'b1;
    send_start(1'b0);
    for (int i = 0; i < 4; i++) send_beat();
    idle(2);
    n_checks++;
    if (wr_cmd_wrbl !== 8'd4 || wr_cmd_wraddr !== 28'd0 || O_overflow !== 1'b0) begin
      n_errors++; $display("FAIL bp_pending: got bl %0d addr %0d ovf %b expected bl 4 addr 0 ovf 0", wr_cmd_wrbl, wr_cmd_wraddr, O_overflow);
    end
    for (int i = 0; i < 4; i++) send_beat();
    idle(3);
    n_checks++;
    if (mc_bl.size() != 0 || wr_cmd_wrbl !== 8'd4 || wr_cmd_wraddr !== 28'd0) begin
      n_errors++; $display("FAIL bp_hold: got %0d pushes bl %0d addr %0d expected 0 pushes bl 4 addr 0", mc_bl.size(), wr_cmd_wrbl, wr_cmd_wraddr);
    end
    n_checks++;
    if (O_overflow !== 1'b1) begin
      n_errors++; $display("FAIL bp_overflow: got %b expected 1", O_overflow);
    end
    I_cmd_full = 1'b0;
    idle(4);
    n_checks++;
    if (mc_bl.size() != 1 || mc_bl[0] !== 8'd4 || mc_addr[0] !== 28'd0) begin
      n_errors++; $display("FAIL bp_release: got %0d pushes expected exactly one (4,0)", mc_bl.size());
    end
    n_checks++;
    if (O_overflow !== 1'b1) begin
      n_errors++; $display("FAIL bp_sticky: got %b expected 1", O_overflow);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    send_start(1'b0);
    send_beat();
    send_beat();
    I_Rst_n = 1'b0;
    idle(2);
    n_checks++;
    if ({wr_fifo_wren, wr_cmd_wren, O_done_pulse, O_overflow} !== 4'b0000 || wr_fifo_wdata !== '0 ||
        wr_cmd_wrbl !== 8'd0 || wr_cmd_wraddr !== 28'd0 || O_done_buf !== 2'd0) begin
      n_errors++; $display("FAIL midrst_outputs: got flags %b bl %0d addr %0d expected all 0",
                           {wr_fifo_wren, wr_cmd_wren, O_done_pulse, O_overflow}, wr_cmd_wrbl, wr_cmd_wraddr);
    end
    I_Rst_n = 1'b1;
    clear_mon();
    model_reset();
    send_start(1'b0);
    for (int i = 0; i < 4; i++) send_beat();
    idle(4);
    n_checks++;
    if (mf_data.size() != 4 || mc_bl.size() != 1 || mc_bl[0] !== 8'd4 || mc_addr[0] !== 28'd0) begin
      n_errors++; $display("FAIL midrst_cmd: got %0d beats %0d cmds expected 4 beats one (4,0)", mf_data.size(), mc_bl.size());
    end
    n_checks++;
    if (O_overflow !== 1'b0) begin
      n_errors++; $display("FAIL midrst_overflow: got %b expected 0", O_overflow);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    send_start(1'b0);
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        send_beat();
        idle($urandom_range(0, 2));
      end
      send_start(1'($urandom_range(0, 1)));
      idle(4);
    end
    idle(4);
    n_checks++;
    if (mf_data.size() != e_fdata.size()) begin
      n_errors++; $display("FAIL rnd_fifo_count: got %0d expected %0d", mf_data.size(), e_fdata.size());
    end else begin
      for (int i = 0; i < e_fdata.size(); i++) begin
        n_checks++;
        if (mf_data[i] !== e_fdata[i]) begin
          n_errors++; $display("FAIL rnd_fifo[%0d]: got %0h expected %0h", i, mf_data[i], e_fdata[i]);
        end
      end
    end
    n_checks++;
    if (mc_bl.size() != e_bl.size()) begin
      n_errors++; $display("FAIL rnd_cmd_count: got %0d expected %0d", mc_bl.size(), e_bl.size());
    end else begin
      for (int i = 0; i < e_bl.size(); i++) begin
        n_checks++;
        if (mc_bl[i] !== 8'(e_bl[i]) || mc_addr[i] !== ADDR_WD'(e_addr[i]) || mc_cmd[i] !== 3'b000) begin
          n_errors++; $display("FAIL rnd_cmd[%0d]: got bl %0d addr %0d cmd %0d expected bl %0d addr %0d cmd 0",
                               i, mc_bl[i], mc_addr[i], mc_cmd[i], e_bl[i], e_addr[i]);
        end
      end
    end
    n_checks++;
    if (md_buf.size() != e_done.size()) begin
      n_errors++; $display("FAIL rnd_done_count: got %0d expected %0d", md_buf.size(), e_done.size());
    end else begin
      for (int i = 0; i < e_done.size(); i++) begin
        n_checks++;
        if (md_buf[i] !== 2'(e_done[i])) begin
          n_errors++; $display("FAIL rnd_done[%0d]: got %0d expected %0d", i, md_buf[i], e_done[i]);
        end
      end
    end
    n_checks++;
    if (O_overflow !== 1'b0) begin
      n_errors++; $display("FAIL rnd_overflow: got %b expected 0", O_overflow);
    end
  endtask

  initial begin
    @(posedge I_clk); #1;
    test_reset();
    test_burst_timing();
    test_wrap();
    test_flush();
    test_rotation();
    test_backpressure();
    test_reset_midburst();
    test_random();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
